// File: rtl/axis_burst_sched.sv
// axis_burst_sched: gates a free-running AXI-Stream source into fixed-length
// packets, generates tlast, inserts idle gaps between packets and ends the run
// after a packet count or on a stop request. Data and keep pass straight through.
module axis_burst_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0]    cfg_pkt_num,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_count
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [LEN_WIDTH-1:0]   beat_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [CNT_WIDTH-1:0]   num_reg;
  logic [GAP_WIDTH-1:0]   gap_reg;
  logic [GAP_WIDTH-1:0]   gap_cnt_reg;
  logic [CNT_WIDTH-1:0]   pkt_count_reg;
  logic                   stop_pend_reg;
  logic                   done_reg;

  logic                   in_send;
  logic                   beat_hs;
  logic                   last_beat;
  logic                   pkt_end;
  logic                   final_pkt;
  logic [CNT_WIDTH-1:0]   pkt_count_inc;

  // Byte-lane pass-through of data and keep; no registers on the data path.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane
      assign m_axis_tdata[gi*8 +: 8] = s_axis_tdata[gi*8 +: 8];
      assign m_axis_tkeep[gi]        = s_axis_tkeep[gi];
    end
  endgenerate

  assign in_send       = (state_reg == ST_SEND);
  assign beat_hs       = in_send & s_axis_tvalid & m_axis_tready;
  assign last_beat     = (beat_reg == (len_reg - LEN_ONE));
  assign pkt_end       = beat_hs & last_beat;
  assign pkt_count_inc = pkt_count_reg + CNT_ONE;
  // The stop request that arrives on the closing beat itself still ends the run.
  assign final_pkt     = ((num_reg != '0) & (pkt_count_inc == num_reg)) |
                         stop_pend_reg | cfg_stop;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision: start, packet end, gap expiry and stop.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pkt_end) begin
          if (final_pkt) begin
            state_next = ST_IDLE;
          end else if (gap_reg == '0) begin
            state_next = ST_SEND;
          end else begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cfg_stop) begin
          state_next = ST_IDLE;
        end else if (gap_cnt_reg <= GAP_ONE) begin
          state_next = ST_SEND;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake gating and status outputs derived from the current state.
  always_comb begin
    m_axis_tvalid = s_axis_tvalid & in_send;
    s_axis_tready = m_axis_tready & in_send;
    m_axis_tlast  = in_send & last_beat;
    busy          = (state_reg != ST_IDLE);
    done          = done_reg;
    pkt_count     = pkt_count_reg;
  end

  // Configuration latch, beat/gap counters, packet counter and done pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_reg      <= '0;
      len_reg       <= '0;
      num_reg       <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      pkt_count_reg <= '0;
      stop_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg != ST_IDLE) && (state_next == ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (cfg_start) begin
            len_reg       <= (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
            num_reg       <= cfg_pkt_num;
            gap_reg       <= cfg_gap;
            pkt_count_reg <= '0;
            beat_reg      <= '0;
            stop_pend_reg <= 1'b0;
          end
        end
        ST_SEND: begin
          if (beat_hs) begin
            if (last_beat) begin
              beat_reg    <= '0;
              gap_cnt_reg <= gap_reg;
              // Unlimited runs hold at all-ones rather than wrapping.
              if (pkt_count_reg != '1) begin
                pkt_count_reg <= pkt_count_inc;
              end
            end else begin
              beat_reg <= beat_reg + LEN_ONE;
            end
          end
          if (cfg_stop && !pkt_end) begin
            stop_pend_reg <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
          end
        end
        default: begin
          beat_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_sched.sv
// Testbench for axis_burst_sched: a counting source feeds the scheduler, and a
// per-cycle behavioural model of the packet/gap/run rules predicts every output.
module tb_axis_burst_sched;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int GW = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic              cfg_start;
  logic              cfg_stop;
  logic [LW-1:0]     cfg_pkt_len;
  logic [CW-1:0]     cfg_pkt_num;
  logic [GW-1:0]     cfg_gap;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DW-1:0]     s_axis_tdata;
  logic [DW/8-1:0]   s_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tkeep;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;
  logic [CW-1:0]     pkt_count;

  always #5 aclk = ~aclk;

  axis_burst_sched #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW),
    .GAP_WIDTH  (GW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_pkt_num   (cfg_pkt_num),
    .cfg_gap       (cfg_gap),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Source counter (the whitehole pattern) and handshake pattern control.
  logic [DW-1:0] src_cnt;
  int            hs_mode;   // 0: always valid/ready, 1: ready toggles, 2: random
  bit            tog;

  // Behavioural model: run flag, idle cycles still owed, position in packet.
  bit            md_run;
  int            md_gap_left;
  int            md_pos;
  int            md_len;
  int            md_gap;
  logic [CW-1:0] md_num;
  logic [CW-1:0] md_pkts;
  bit            md_stop_req;
  bit            md_done;

  // Observed traffic since the last start_run.
  int acc_beats;
  int acc_lasts;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW/8-1:0] keep_of(input logic [DW-1:0] d);
    logic [DW-1:0] t;
    t = d ^ (d >> 4);
    return t[DW/8-1:0];
  endfunction

  task automatic model_reset();
    md_run      = 1'b0;
    md_gap_left = 0;
    md_pos      = 0;
    md_pkts     = '0;
    md_stop_req = 1'b0;
    md_done     = 1'b0;
  endtask

  // One clock cycle: drive handshake inputs, compare outputs against the model,
  // then advance the model and the source across the rising edge.
  task automatic tick();
    bit send, exp_v, exp_r, exp_l, hs_exp, src_hs;
    case (hs_mode)
      0: begin s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; end
      1: begin s_axis_tvalid = 1'b1; m_axis_tready = tog; end
      default: begin
        s_axis_tvalid = ($urandom_range(0, 3) != 0);
        m_axis_tready = ($urandom_range(0, 2) != 0);
      end
    endcase
    tog = ~tog;
    s_axis_tdata = src_cnt;
    s_axis_tkeep = keep_of(src_cnt);
    #1;
    send  = md_run && (md_gap_left == 0);
    exp_v = s_axis_tvalid && send;
    exp_r = m_axis_tready && send;
    exp_l = send && (md_pos == md_len - 1);
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
    chk("s_tready", 64'(s_axis_tready), 64'(exp_r));
    chk("m_tlast", 64'(m_axis_tlast), 64'(exp_l));
    chk("busy", 64'(busy), 64'(md_run));
    chk("done", 64'(done), 64'(md_done));
    chk("pkt_count", 64'(pkt_count), 64'(md_pkts));
    if (exp_v) begin
      chk("tdata", 64'(m_axis_tdata), 64'(src_cnt));
      chk("tkeep", 64'(m_axis_tkeep), 64'(keep_of(src_cnt)));
    end
    src_hs = s_axis_tvalid && s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      acc_beats++;
      if (m_axis_tlast) acc_lasts++;
    end
    hs_exp = exp_v && m_axis_tready;
    @(posedge aclk);
    if (src_hs) src_cnt = src_cnt + 1;
    if (areset) begin
      model_reset();
    end else begin
      md_done = 1'b0;
      if (!md_run) begin
        if (cfg_start) begin
          md_len      = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
          md_num      = cfg_pkt_num;
          md_gap      = int'(cfg_gap);
          md_run      = 1'b1;
          md_gap_left = 0;
          md_pos      = 0;
          md_pkts     = '0;
          md_stop_req = 1'b0;
        end
      end else if (md_gap_left > 0) begin
        if (cfg_stop) begin
          md_run      = 1'b0;
          md_done     = 1'b1;
          md_gap_left = 0;
        end else begin
          md_gap_left--;
        end
      end else if (hs_exp && (md_pos == md_len - 1)) begin
        md_pos = 0;
        if (md_pkts != '1) md_pkts = md_pkts + 1;
        if (((md_num != 0) && (md_pkts == md_num)) || md_stop_req || cfg_stop) begin
          md_run  = 1'b0;
          md_done = 1'b1;
        end else begin
          md_gap_left = md_gap;
        end
      end else begin
        if (hs_exp) md_pos++;
        if (cfg_stop) md_stop_req = 1'b1;
      end
    end
    @(negedge aclk);
  endtask

  // Pulse cfg_start with the given settings, then scramble cfg_* so that any
  // dependence on the live config after the start would show up.
  task automatic start_run(input int len, input int num, input int gap);
    acc_beats   = 0;
    acc_lasts   = 0;
    cfg_pkt_len = LW'(len);
    cfg_pkt_num = CW'(num);
    cfg_gap     = GW'(gap);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
    cfg_pkt_len = LW'($urandom_range(0, 9));
    cfg_pkt_num = CW'($urandom_range(0, 9));
    cfg_gap     = GW'($urandom_range(0, 9));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk("idle_timeout", 64'(busy), 64'd0);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && acc_beats < n; i++) tick();
    chk("beat_timeout", 64'(acc_beats >= n), 64'd1);
  endtask

  initial begin
    areset        = 1'b1;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_pkt_len   = '0;
    cfg_pkt_num   = '0;
    cfg_gap       = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    src_cnt       = '0;
    hs_mode       = 0;
    tog           = 1'b1;
    md_len        = 1;
    md_gap        = 0;
    md_num        = '0;
    acc_beats     = 0;
    acc_lasts     = 0;
    model_reset();

    // Reset state, with the source offering data throughout.
    @(negedge aclk);
    repeat (3) tick();
    areset = 1'b0;
    tick();

    // len=4 num=3 gap=2, sink always ready.
    hs_mode = 0;
    start_run(4, 3, 2);
    wait_idle(200);
    chk("s1_beats", 64'(acc_beats), 64'd12);
    chk("s1_lasts", 64'(acc_lasts), 64'd3);
    chk("s1_pkts", 64'(pkt_count), 64'd3);

    // Same config with ready toggling.
    hs_mode = 1;
    start_run(4, 3, 2);
    wait_idle(200);
    chk("s2_beats", 64'(acc_beats), 64'd12);
    chk("s2_lasts", 64'(acc_lasts), 64'd3);
    chk("s2_pkts", 64'(pkt_count), 64'd3);

    // len=0 is a single-beat packet; two back-to-back.
    hs_mode = 0;
    start_run(0, 2, 0);
    wait_idle(50);
    chk("s3_beats", 64'(acc_beats), 64'd2);
    chk("s3_lasts", 64'(acc_lasts), 64'd2);
    chk("s3_pkts", 64'(pkt_count), 64'd2);

    // Unlimited run, stop after the 3rd beat of the 5th packet.
    start_run(8, 0, 1);
    wait_beats(35, 300);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle(100);
    chk("s4_beats", 64'(acc_beats), 64'd40);
    chk("s4_pkts", 64'(pkt_count), 64'd5);
    chk("s4_busy", 64'(busy), 64'd0);

    // Stop during a long gap; a start while busy must be ignored.
    start_run(3, 0, 10);
    cfg_pkt_len = LW'(7);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
    wait_beats(3, 50);
    repeat (3) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    repeat (6) tick();
    chk("s5_beats", 64'(acc_beats), 64'd3);
    chk("s5_pkts", 64'(pkt_count), 64'd1);
    chk("s5_busy", 64'(busy), 64'd0);

    // Reset mid-packet, then a fresh run.
    start_run(6, 0, 0);
    wait_beats(3, 50);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_cnt", 64'(pkt_count), 64'd0);
    start_run(2, 1, 0);
    wait_idle(50);
    chk("s6_beats", 64'(acc_beats), 64'd2);
    chk("s6_lasts", 64'(acc_lasts), 64'd1);
    chk("s6_pkts", 64'(pkt_count), 64'd1);

    // Randomized runs with random handshakes, stops, spurious starts and resets.
    for (int r = 0; r < 20; r++) begin
      hs_mode = 2;
      start_run($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3));
      for (int k = 0; k < 100; k++) begin
        cfg_stop  = ($urandom_range(0, 39) == 0);
        cfg_start = ($urandom_range(0, 19) == 0);
        areset    = ($urandom_range(0, 199) == 0);
        tick();
        cfg_stop  = 1'b0;
        cfg_start = 1'b0;
        areset    = 1'b0;
      end
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      wait_idle(200);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
